// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2c_pkg
// Description : Shared constants for the I2C register-interface slave:
//               FSM state encoding, ACK/NACK levels and R/W bit values.
// Revision    : 1.0 - initial release
// ============================================================================
package i2c_pkg;

  localparam int c_STATE_W = 4;

  localparam logic [c_STATE_W-1:0] c_ST_IDLE     = 4'd0;
  localparam logic [c_STATE_W-1:0] c_ST_DEV_ADDR = 4'd1;
  localparam logic [c_STATE_W-1:0] c_ST_DEV_ACK  = 4'd2;
  localparam logic [c_STATE_W-1:0] c_ST_REG_ADDR = 4'd3;
  localparam logic [c_STATE_W-1:0] c_ST_REG_ACK  = 4'd4;
  localparam logic [c_STATE_W-1:0] c_ST_WR_DATA  = 4'd5;
  localparam logic [c_STATE_W-1:0] c_ST_WR_ACK   = 4'd6;
  localparam logic [c_STATE_W-1:0] c_ST_RD_DATA  = 4'd7;
  localparam logic [c_STATE_W-1:0] c_ST_RD_ACK   = 4'd8;
  localparam logic [c_STATE_W-1:0] c_ST_WAIT     = 4'd9;

  // SDA level seen during the acknowledge bit
  localparam logic c_ACK  = 1'b0;
  localparam logic c_NACK = 1'b1;

  // Bit 0 of the device-address byte
  localparam logic c_RW_WRITE = 1'b0;
  localparam logic c_RW_READ  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/i2c_bus_sync.sv
`default_nettype none
// ============================================================================
// Module      : i2c_bus_sync
// Description : SCL/SDA synchronisers, SCL edge detection and one-clk
//               START/STOP pulses derived from the synchronised bus.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_d;
  logic                   r_sda_d;
  // Fills with ones after reset; detection is held off until the delayed
  // copies hold real bus samples, so leaving reset mid-transfer cannot
  // fabricate a START or STOP.
  logic [SYNC_STAGES:0]   r_prime;
  logic                   w_scl;
  logic                   w_sda;
  logic                   w_primed;

  assign w_scl    = r_scl_sync[SYNC_STAGES-1];
  assign w_sda    = r_sda_sync[SYNC_STAGES-1];
  assign w_primed = r_prime[SYNC_STAGES];

  // Synchroniser chains and one-clk-delayed copies; reset to the idle bus level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
      r_prime    <= '0;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_i};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_i};
      r_scl_d    <= w_scl;
      r_sda_d    <= w_sda;
      r_prime    <= {r_prime[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign sda      = w_sda;
  assign scl_rise = w_primed &  w_scl & ~r_scl_d;
  assign scl_fall = w_primed & ~w_scl &  r_scl_d;
  assign start    = w_primed &  w_scl &  r_scl_d &  r_sda_d & ~w_sda;
  assign stop     = w_primed &  w_scl &  r_scl_d & ~r_sda_d &  w_sda;

endmodule
`default_nettype wire

// File: rtl/i2c_slave_regif.sv
`default_nettype none
// ============================================================================
// Module      : i2c_slave_regif
// Description : I2C slave exposing a byte-wide register file through a
//               pointer/strobe interface. Writes: dev addr, reg addr, data.
//               Reads continue from the persistent register pointer.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_slave_regif
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = 7'h50,
  parameter int         MEM_AW      = 5,
  parameter int         SYNC_STAGES = 2,
  parameter bit         AUTO_INC    = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              sda_oe,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata,
  output logic              busy
);

  logic                 w_sda;
  logic                 w_scl_rise;
  logic                 w_scl_fall;
  logic                 w_start;
  logic                 w_stop;

  logic [c_STATE_W-1:0] r_state;
  logic [c_STATE_W-1:0] w_state_nxt;

  // r_cnt counts SCL rises inside a byte; 8 means the byte is complete and
  // the block is waiting for the SCL fall that opens the acknowledge bit.
  logic [3:0]           r_cnt, w_cnt_nxt;
  logic [7:0]           r_shift, w_shift_nxt;
  logic [7:0]           r_tx, w_tx_nxt;
  logic [MEM_AW-1:0]    r_ptr, w_ptr_nxt;
  logic                 r_rw, w_rw_nxt;
  logic                 r_mack, w_mack_nxt;
  logic                 r_sda_oe, w_sda_oe_nxt;
  logic                 r_we, w_we_nxt;
  logic [7:0]           r_wdata, w_wdata_nxt;
  logic                 r_re, w_re_nxt;
  logic                 r_busy, w_busy_nxt;
  logic                 r_load;

  logic [7:0]           w_byte;
  logic                 w_byte_done;
  logic                 w_addr_hit;

  i2c_bus_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_bus_sync (
    .clk      (clk),
    .rst      (rst),
    .scl_i    (scl_i),
    .sda_i    (sda_i),
    .sda      (w_sda),
    .scl_rise (w_scl_rise),
    .scl_fall (w_scl_fall),
    .start    (w_start),
    .stop     (w_stop)
  );

  // Byte as it will look once the bit on the current SCL rise is shifted in
  assign w_byte      = {r_shift[6:0], w_sda};
  assign w_byte_done = (r_cnt == 4'd8);
  assign w_addr_hit  = (r_shift[7:1] == DEV_ADDR);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= c_ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic: bus conditions first, then byte/ack boundaries on SCL fall
  always_comb begin
    w_state_nxt = r_state;
    if (w_stop) begin
      w_state_nxt = c_ST_IDLE;
    end else if (w_start) begin
      w_state_nxt = c_ST_DEV_ADDR;
    end else if (w_scl_fall) begin
      case (r_state)
        c_ST_DEV_ADDR: if (w_byte_done) w_state_nxt = w_addr_hit ? c_ST_DEV_ACK : c_ST_WAIT;
        c_ST_DEV_ACK:  w_state_nxt = (r_rw == c_RW_READ) ? c_ST_RD_DATA : c_ST_REG_ADDR;
        c_ST_REG_ADDR: if (w_byte_done) w_state_nxt = c_ST_REG_ACK;
        c_ST_REG_ACK:  w_state_nxt = c_ST_WR_DATA;
        c_ST_WR_DATA:  if (w_byte_done) w_state_nxt = c_ST_WR_ACK;
        c_ST_WR_ACK:   w_state_nxt = c_ST_WR_DATA;
        c_ST_RD_DATA:  if (w_byte_done) w_state_nxt = c_ST_RD_ACK;
        c_ST_RD_ACK:   w_state_nxt = (r_mack == c_ACK) ? c_ST_RD_DATA : c_ST_WAIT;
        default:       w_state_nxt = r_state;
      endcase
    end
  end

  // Output/datapath logic: sampling on SCL rise, SDA drive changes on SCL fall
  always_comb begin
    w_cnt_nxt    = r_cnt;
    w_shift_nxt  = r_shift;
    w_tx_nxt     = r_tx;
    w_ptr_nxt    = r_ptr;
    w_rw_nxt     = r_rw;
    w_mack_nxt   = r_mack;
    w_sda_oe_nxt = r_sda_oe;
    w_we_nxt     = 1'b0;
    w_wdata_nxt  = r_wdata;
    w_re_nxt     = 1'b0;
    w_busy_nxt   = r_busy;

    // Read data is valid the clk after the read strobe
    if (r_load) w_tx_nxt = mem_rdata;

    if (w_start || w_stop) begin
      // Any partial byte is dropped; nothing is written
      w_cnt_nxt    = 4'd0;
      w_shift_nxt  = 8'd0;
      w_sda_oe_nxt = 1'b0;
      w_busy_nxt   = 1'b0;
    end else begin
      if (w_scl_rise) begin
        case (r_state)
          c_ST_DEV_ADDR, c_ST_REG_ADDR, c_ST_WR_DATA: begin
            if (!w_byte_done) begin
              w_shift_nxt = w_byte;
              w_cnt_nxt   = r_cnt + 4'd1;
              if (r_cnt == 4'd7 && r_state == c_ST_REG_ADDR) begin
                w_ptr_nxt = w_byte[MEM_AW-1:0];
              end
              if (r_cnt == 4'd7 && r_state == c_ST_WR_DATA) begin
                w_we_nxt    = 1'b1;
                w_wdata_nxt = w_byte;
              end
            end
          end
          c_ST_DEV_ACK: begin
            if (r_rw == c_RW_READ) w_re_nxt = 1'b1;
          end
          c_ST_RD_DATA: begin
            if (!w_byte_done) w_cnt_nxt = r_cnt + 4'd1;
          end
          c_ST_RD_ACK: begin
            w_mack_nxt = w_sda;
            if (w_sda == c_ACK) begin
              w_re_nxt = 1'b1;
              if (AUTO_INC) w_ptr_nxt = r_ptr + MEM_AW'(1);
            end
          end
          default: ;
        endcase
      end

      if (w_scl_fall) begin
        case (r_state)
          c_ST_DEV_ADDR: begin
            if (w_byte_done) begin
              w_cnt_nxt = 4'd0;
              if (w_addr_hit) begin
                w_sda_oe_nxt = 1'b1;
                w_rw_nxt     = r_shift[0];
                w_busy_nxt   = 1'b1;
              end
            end
          end
          c_ST_REG_ADDR, c_ST_WR_DATA: begin
            if (w_byte_done) begin
              w_cnt_nxt    = 4'd0;
              w_sda_oe_nxt = 1'b1;
              if (r_state == c_ST_WR_DATA && AUTO_INC) w_ptr_nxt = r_ptr + MEM_AW'(1);
            end
          end
          c_ST_DEV_ACK: begin
            w_sda_oe_nxt = 1'b0;
            if (r_rw == c_RW_READ) begin
              w_sda_oe_nxt = ~r_tx[7];
              w_tx_nxt     = {r_tx[6:0], 1'b0};
            end
          end
          c_ST_REG_ACK, c_ST_WR_ACK: begin
            w_sda_oe_nxt = 1'b0;
          end
          c_ST_RD_DATA: begin
            if (w_byte_done) begin
              w_cnt_nxt    = 4'd0;
              w_sda_oe_nxt = 1'b0;
            end else begin
              w_sda_oe_nxt = ~r_tx[7];
              w_tx_nxt     = {r_tx[6:0], 1'b0};
            end
          end
          c_ST_RD_ACK: begin
            w_sda_oe_nxt = 1'b0;
            if (r_mack == c_ACK) begin
              w_sda_oe_nxt = ~r_tx[7];
              w_tx_nxt     = {r_tx[6:0], 1'b0};
            end
          end
          default: w_sda_oe_nxt = 1'b0;
        endcase
      end
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= 4'd0;
      r_shift  <= 8'd0;
      r_tx     <= 8'd0;
      r_ptr    <= '0;
      r_rw     <= 1'b0;
      r_mack   <= 1'b0;
      r_sda_oe <= 1'b0;
      r_we     <= 1'b0;
      r_wdata  <= 8'd0;
      r_re     <= 1'b0;
      r_busy   <= 1'b0;
      r_load   <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_shift  <= w_shift_nxt;
      r_tx     <= w_tx_nxt;
      r_ptr    <= w_ptr_nxt;
      r_rw     <= w_rw_nxt;
      r_mack   <= w_mack_nxt;
      r_sda_oe <= w_sda_oe_nxt;
      r_we     <= w_we_nxt;
      r_wdata  <= w_wdata_nxt;
      r_re     <= w_re_nxt;
      r_busy   <= w_busy_nxt;
      r_load   <= r_re;
    end
  end

  assign sda_oe    = r_sda_oe;
  assign mem_addr  = r_ptr;
  assign mem_we    = r_we;
  assign mem_wdata = r_wdata;
  assign mem_re    = r_re;
  assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_regif.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_slave_regif
// Description : Self-checking bench. Two slaves share one bus: device 0
//               (addr 0x50, auto-increment) and device 1 (addr 0x3C, fixed
//               pointer). A bit-level master drives directed and random
//               transactions; a register-file model predicts all results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_slave_regif;
  import i2c_pkg::*;

  localparam int Q = 80;  // quarter SCL period (8 clks)

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       sda_line;
  logic       oe0, oe1, we0, we1, re0, re1, busy0, busy1;
  logic [4:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic [7:0] rdata0 = 8'h00;
  logic [7:0] rdata1 = 8'h00;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  // Open-drain bus: anyone pulling low wins
  assign sda_line = m_sda & ~oe0 & ~oe1;

  i2c_slave_regif #(.DEV_ADDR(7'h50), .MEM_AW(5), .SYNC_STAGES(2), .AUTO_INC(1'b1)) u_dut0 (
    .clk(clk), .rst(rst), .scl_i(m_scl), .sda_i(sda_line), .sda_oe(oe0),
    .mem_addr(addr0), .mem_we(we0), .mem_wdata(wdata0), .mem_re(re0),
    .mem_rdata(rdata0), .busy(busy0));

  i2c_slave_regif #(.DEV_ADDR(7'h3C), .MEM_AW(5), .SYNC_STAGES(3), .AUTO_INC(1'b0)) u_dut1 (
    .clk(clk), .rst(rst), .scl_i(m_scl), .sda_i(sda_line), .sda_oe(oe1),
    .mem_addr(addr1), .mem_we(we1), .mem_wdata(wdata1), .mem_re(re1),
    .mem_rdata(rdata1), .busy(busy1));

  // Register files behind each slave (synchronous read, one-clk latency)
  logic [7:0] mem [2][32];
  logic       pl_en = 1'b0;
  logic [0:0] pl_d  = 1'b0;
  logic [4:0] pl_a  = 5'd0;
  logic [7:0] pl_v  = 8'd0;
  always @(posedge clk) begin
    if (pl_en) mem[pl_d][pl_a] <= pl_v;
    if (we0)   mem[0][addr0]   <= wdata0;
    if (we1)   mem[1][addr1]   <= wdata1;
    if (re0)   rdata0 <= mem[0][addr0];
    if (re1)   rdata1 <= mem[1][addr1];
  end

  // Monitors: observed writes, strobe counts, busy and SDA-drive timing
  logic [13:0] wq[$];
  int          re_n   = 0;
  int          busy_n = 0;
  int          oe_bad = 0;
  logic [1:0]  oe_prev = 2'b00;
  always @(negedge clk) begin
    if (we0) wq.push_back({1'b0, addr0, wdata0});
    if (we1) wq.push_back({1'b1, addr1, wdata1});
    if (re0) re_n++;
    if (re1) re_n++;
    if (busy0 || busy1) busy_n++;
    if (rst && ({oe0, oe1} != oe_prev) && m_scl) oe_bad++;
    oe_prev <= {oe0, oe1};
  end

  // Reference model state
  logic [7:0] ref_mem [2][32];
  logic [4:0] ref_ptr [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic preload(input int d, input int a, input logic [7:0] v);
    pl_d = d[0:0]; pl_a = a[4:0]; pl_v = v; pl_en = 1'b1;
    @(posedge clk); #1 pl_en = 1'b0;
    ref_mem[d][a] = v;
  endtask

  function automatic logic [7:0] dev_byte(input int d, input logic rw);
    return {(d == 0) ? 7'h50 : 7'h3C, rw};
  endfunction

  // ---------------- bit-level master ----------------
  task automatic bus_start;
    m_sda = 1'b1; #Q; m_scl = 1'b1; #Q; m_sda = 1'b0; #Q; m_scl = 1'b0; #Q;
  endtask

  task automatic bus_stop;
    m_sda = 1'b0; #Q; m_scl = 1'b1; #Q; m_sda = 1'b1; #Q;
  endtask

  task automatic write_bit(input logic b);
    m_sda = b; #Q; m_scl = 1'b1; #(2*Q); m_scl = 1'b0; #Q;
  endtask

  task automatic read_bit(output logic b);
    m_sda = 1'b1; #Q; m_scl = 1'b1; #Q; b = sda_line; #Q; m_scl = 1'b0; #Q;
  endtask

  task automatic write_byte(input logic [7:0] v, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(v[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] v, input logic ack);
    logic b;
    v = 8'h00;
    for (int i = 0; i < 8; i++) begin
      read_bit(b);
      v = {v[6:0], b};
    end
    write_bit(ack);
  endtask

  task automatic check_ptrs;
    chk("ptr_dev0", {27'd0, addr0}, {27'd0, ref_ptr[0]});
    chk("ptr_dev1", {27'd0, addr1}, {27'd0, ref_ptr[1]});
  endtask

  // ---------------- transactions with model prediction ----------------
  task automatic do_write(input int d, input logic [7:0] ra, input int n, input logic [31:0] data);
    logic        ack;
    logic [7:0]  b;
    logic [13:0] ewq[$];
    int          p = int'(ra[4:0]);
    int          base = wq.size();
    int          re0_base = re_n;
    bus_start;
    write_byte(dev_byte(d, c_RW_WRITE), ack); chk("wr_dev_ack", {31'd0, ack}, {31'd0, c_ACK});
    chk("busy_in_xfer", {31'd0, (d == 0) ? busy0 : busy1}, 32'd1);
    write_byte(ra, ack); chk("wr_reg_ack", {31'd0, ack}, {31'd0, c_ACK});
    for (int i = 0; i < n; i++) begin
      b = data[31-8*i -: 8];
      write_byte(b, ack); chk("wr_data_ack", {31'd0, ack}, {31'd0, c_ACK});
      ewq.push_back({d[0], p[4:0], b});
      ref_mem[d][p] = b;
      if (d == 0) p = (p + 1) % 32;
    end
    bus_stop;
    ref_ptr[d] = p[4:0];
    chk("wr_count", wq.size() - base, ewq.size());
    for (int i = 0; i < ewq.size(); i++)
      if (base + i < wq.size()) chk("wr_entry", {18'd0, wq[base+i]}, {18'd0, ewq[i]});
    chk("wr_no_read", re_n - re0_base, 0);
    chk("busy_after_stop", {31'd0, busy0 | busy1}, 32'd0);
    check_ptrs;
  endtask

  task automatic do_read(input int d, input bit use_reg, input logic [7:0] ra, input int n);
    logic       ack;
    logic [7:0] b;
    int         p = use_reg ? int'(ra[4:0]) : int'(ref_ptr[d]);
    int         base = wq.size();
    int         re0_base = re_n;
    bus_start;
    if (use_reg) begin
      write_byte(dev_byte(d, c_RW_WRITE), ack); chk("rd_wdev_ack", {31'd0, ack}, {31'd0, c_ACK});
      write_byte(ra, ack); chk("rd_reg_ack", {31'd0, ack}, {31'd0, c_ACK});
      bus_start;
    end
    write_byte(dev_byte(d, c_RW_READ), ack); chk("rd_dev_ack", {31'd0, ack}, {31'd0, c_ACK});
    chk("busy_in_read", {31'd0, (d == 0) ? busy0 : busy1}, 32'd1);
    for (int i = 0; i < n; i++) begin
      read_byte(b, (i == n - 1) ? c_NACK : c_ACK);
      chk("rd_data", {24'd0, b}, {24'd0, ref_mem[d][p]});
      if (i != n - 1 && d == 0) p = (p + 1) % 32;
    end
    bus_stop;
    ref_ptr[d] = p[4:0];
    chk("rd_strobes", re_n - re0_base, n);
    chk("rd_no_write", wq.size() - base, 0);
    check_ptrs;
  endtask

  initial begin
    logic       ack;
    logic       bit_v;
    int         base;
    int         re_base;
    int         busy_base;
    ref_ptr[0] = 5'd0;
    ref_ptr[1] = 5'd0;

    // Reset state
    repeat (4) @(posedge clk);
    #1;
    chk("rst_sda_oe", {31'd0, oe0 | oe1}, 32'd0);
    chk("rst_busy",   {31'd0, busy0 | busy1}, 32'd0);
    chk("rst_we_re",  {30'd0, we0 | we1, re0 | re1}, 32'd0);
    chk("rst_wdata",  {24'd0, wdata0}, 32'd0);
    chk("rst_state",  {28'd0, u_dut0.r_state}, {28'd0, c_ST_IDLE});
    check_ptrs;
    @(negedge clk) rst = 1'b1;
    repeat (4) @(posedge clk);

    for (int d = 0; d < 2; d++)
      for (int a = 0; a < 32; a++) preload(d, a, 8'($urandom));

    // Two-byte write with auto-increment
    do_write(0, 8'h03, 2, 32'h1122_0000);

    // Pointer 0x1F, repeated start, two-byte read wrapping to 0
    preload(0, 31, 8'h5A);
    preload(0, 0, 8'hC3);
    do_read(0, 1'b1, 8'h1F, 2);

    // Unknown address: NACK, no strobes, never busy
    base = wq.size(); re_base = re_n; busy_base = busy_n;
    bus_start;
    write_byte(8'hA2, ack); chk("nomatch_nack", {31'd0, ack}, {31'd0, c_NACK});
    write_byte(8'h55, ack); chk("wait_nack", {31'd0, ack}, {31'd0, c_NACK});
    bus_stop;
    chk("nomatch_busy", busy_n - busy_base, 0);
    chk("nomatch_strobes", (wq.size() - base) + (re_n - re_base), 0);

    // STOP after four data bits: no write, idle, pointer loaded
    base = wq.size();
    bus_start;
    write_byte(8'hA0, ack); chk("abort_dev_ack", {31'd0, ack}, {31'd0, c_ACK});
    write_byte(8'h05, ack); chk("abort_reg_ack", {31'd0, ack}, {31'd0, c_ACK});
    for (int i = 0; i < 4; i++) write_bit(1'($urandom));
    bus_stop;
    ref_ptr[0] = 5'd5;
    chk("abort_no_write", wq.size() - base, 0);
    chk("abort_state", {28'd0, u_dut0.r_state}, {28'd0, c_ST_IDLE});
    check_ptrs;

    // Fixed-pointer device: both bytes land at register 2
    do_write(1, 8'h02, 2, 32'h0102_0000);

    // Random traffic to both devices
    for (int t = 0; t < 12; t++) begin
      if ($urandom_range(0, 1) == 1)
        do_write($urandom_range(0, 1), 8'($urandom), $urandom_range(1, 3), $urandom);
      else
        do_read($urandom_range(0, 1), 1'($urandom), 8'($urandom), $urandom_range(1, 3));
    end

    // Reset in the middle of a read byte
    bus_start;
    write_byte(8'hA1, ack); chk("rstmid_dev_ack", {31'd0, ack}, {31'd0, c_ACK});
    for (int i = 0; i < 3; i++) read_bit(bit_v);
    rst = 1'b0;
    #1;
    chk("rstmid_sda_oe", {31'd0, oe0}, 32'd0);
    chk("rstmid_busy", {31'd0, busy0}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    ref_ptr[0] = 5'd0;
    ref_ptr[1] = 5'd0;
    for (int i = 0; i < 6; i++) read_bit(bit_v);
    bus_stop;
    chk("rstmid_state", {28'd0, u_dut0.r_state}, {28'd0, c_ST_IDLE});
    check_ptrs;
    do_write(0, 8'($urandom), 2, $urandom);
    do_read(0, 1'b1, 8'($urandom), 3);

    chk("sda_oe_only_scl_low", oe_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
